lut_delay_pipeline: RTL and testbench

- Parametrised successor to the fixed two-stage index delay line plus 4-entry ROM lookup.
- An index stream passes through a DELAY-stage valid-tagged shift pipeline, then addresses a writable lookup table (LUT) with a registered read.
- Adds ready/valid backpressure, a runtime LUT write port, a sticky event flag with clear, a threshold comparator and an accepted-transaction counter.
- Sits between control logic producing table indices and downstream datapath consumers.

---
 rtl/lut_delay_pipeline_if.sv | 52 +++++
 rtl/lut_delay_pipeline.sv | 102 ++++++++++
 tb/tb_lut_delay_pipeline.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/lut_delay_pipeline_if.sv
// Bundle of the stream, LUT-write, threshold and sticky-flag signals of
// lut_delay_pipeline. Clock and reset stay outside as plain ports.
// The master side drives the index stream and the control inputs.
// The slave side is the pipeline itself.
interface lut_delay_pipeline_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2,
  parameter int CNT_W  = 16
);

  // Index stream into the pipeline
  logic [IDX_W-1:0]  in_idx;
  logic              in_vld;
  logic              in_rd;

  // LUT data stream out of the pipeline
  logic [DATA_W-1:0] out_data;
  logic              out_vld;
  logic              out_rd;

  // Runtime LUT write port
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Threshold comparator on the output data
  logic [DATA_W-1:0] cmp_thr;
  logic              out_ge_thr;

  // Sticky event flag
  logic              sticky_set;
  logic              sticky_clr;
  logic              sticky;

  // Count of accepted input transfers
  logic [CNT_W-1:0]  acc_cnt;

  modport master (
    output in_idx, in_vld, out_rd,
    output wr_en, wr_addr, wr_data,
    output cmp_thr, sticky_set, sticky_clr,
    input  in_rd, out_data, out_vld, out_ge_thr, sticky, acc_cnt
  );

  modport slave (
    input  in_idx, in_vld, out_rd,
    input  wr_en, wr_addr, wr_data,
    input  cmp_thr, sticky_set, sticky_clr,
    output in_rd, out_data, out_vld, out_ge_thr, sticky, acc_cnt
  );

endinterface

// File: rtl/lut_delay_pipeline.sv
// Index delay line feeding a writable lookup table with a registered read.
// Each index travels through DELAY valid-tagged stages, then addresses the
// LUT. The whole pipeline stalls as one unit when the output is held, and
// bubbles travel through it without being collapsed.
// Side functions: a runtime LUT write port (read-before-write on the same
// edge), an unsigned threshold compare on the output, a sticky event flag
// and a wrapping count of accepted input transfers.
module lut_delay_pipeline #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2,
  parameter int DELAY  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lut_delay_pipeline_if.slave  bus
);

  localparam int LUT_N = 1 << IDX_W;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } stage_t;

  typedef logic [DATA_W-1:0] lut_t [LUT_N];

  // Power-up table contents: entry k holds k, truncated to DATA_W bits.
  function automatic lut_t lut_init();
    lut_t tbl;
    for (int k = 0; k < LUT_N; k++) begin
      tbl[k] = DATA_W'(k);
    end
    return tbl;
  endfunction

  lut_t              lut_mem = lut_init();
  stage_t            stage_q [DELAY];
  logic [DATA_W-1:0] out_data_q;
  logic              out_vld_q;
  logic              sticky_q;
  logic [CNT_W-1:0]  acc_cnt_q;
  logic              en;
  logic              accept;

  // The pipeline moves only when the output register is empty or being
  // drained. The same signal is the input ready.
  assign en     = !out_vld_q || bus.out_rd;
  assign accept = bus.in_vld && en;

  // Index delay stages and the registered LUT read, all gated by en
  // NOTE: every register is updated with <= so that all stages sample the
  // pre-edge values of their neighbours and shift as a unit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < DELAY; n++) begin
        stage_q[n] <= '0;
      end
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
    end else if (en) begin
      stage_q[0] <= stage_t'({bus.in_vld, bus.in_idx});
      for (int n = 1; n < DELAY; n++) begin
        stage_q[n] <= stage_q[n-1];
      end
      out_data_q <= lut_mem[stage_q[DELAY-1].idx];
      out_vld_q  <= stage_q[DELAY-1].vld;
    end
  end

  // LUT write port. It runs even while stalled or in reset. A read of the
  // same entry on the same edge sees the old value.
  // NOTE: the table has no reset branch. Its contents must survive rst_n,
  // and leaving the reset out also lets the array map onto plain RAM or
  // distributed LUT storage.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      lut_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Sticky flag (set wins over clear) and the wrapping accept counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q  <= 1'b0;
      acc_cnt_q <= '0;
    end else begin
      sticky_q <= bus.sticky_set || (sticky_q && !bus.sticky_clr);
      if (accept) begin
        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_rd      = en;
  assign bus.out_data   = out_data_q;
  assign bus.out_vld    = out_vld_q;
  assign bus.out_ge_thr = (out_data_q >= bus.cmp_thr);
  assign bus.sticky     = sticky_q;
  assign bus.acc_cnt    = acc_cnt_q;

endmodule

// File: tb/tb_lut_delay_pipeline.sv
// Self-checking bench for lut_delay_pipeline. The reference model is
// transaction-level. Each accepted index is due at the output DELAY advance
// edges after it is accepted. It picks up the table value held at that edge,
// before any write on the same edge takes effect.
module tb_lut_delay_pipeline;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 2;
  localparam int DELAY  = 2;
  localparam int CNT_W  = 16;
  localparam int LUT_N  = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lut_delay_pipeline_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  lut_delay_pipeline #(
    .DATA_W(DATA_W), .IDX_W(IDX_W), .DELAY(DELAY), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [IDX_W-1:0] idx;
    int unsigned      due;
  } item_t;

  item_t             inflight [$];
  logic [DATA_W-1:0] ref_lut [LUT_N];
  int unsigned       n_adv;
  logic              exp_vld;
  logic [DATA_W-1:0] exp_data;
  logic              exp_sticky;
  logic [CNT_W-1:0]  exp_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle. Inputs must already be driven. The task checks in_rd,
  // steps the model over the edge, then checks the registered outputs.
  task automatic cycle();
    logic en;
    #1;
    en = !exp_vld || bus.out_rd;
    check("in_rd", {31'd0, bus.in_rd}, {31'd0, en});
    @(posedge clk);
    if (!rst_n) begin
      inflight.delete();
      exp_vld    = 1'b0;
      exp_data   = '0;
      exp_sticky = 1'b0;
      exp_cnt    = '0;
    end else begin
      if (en) begin
        n_adv++;
        if (inflight.size() > 0 && inflight[0].due == n_adv) begin
          exp_vld  = 1'b1;
          exp_data = ref_lut[inflight[0].idx];
          void'(inflight.pop_front());
        end else begin
          exp_vld = 1'b0;
        end
        if (bus.in_vld) begin
          inflight.push_back('{idx: bus.in_idx, due: n_adv + DELAY});
          exp_cnt = exp_cnt + 1'b1;
        end
      end
      exp_sticky = bus.sticky_set || (exp_sticky && !bus.sticky_clr);
    end
    if (bus.wr_en) ref_lut[bus.wr_addr] = bus.wr_data;
    #1;
    check("out_vld", {31'd0, bus.out_vld}, {31'd0, exp_vld});
    if (exp_vld) begin
      check("out_data", 32'(bus.out_data), 32'(exp_data));
      check("out_ge_thr", {31'd0, bus.out_ge_thr}, {31'd0, exp_data >= bus.cmp_thr});
    end
    if (!rst_n) check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("acc_cnt", 32'(bus.acc_cnt), 32'(exp_cnt));
    check("sticky", {31'd0, bus.sticky}, {31'd0, exp_sticky});
  endtask

  task automatic drive(input logic vld, input logic [IDX_W-1:0] idx, input logic ordy);
    bus.in_vld = vld;
    bus.in_idx = idx;
    bus.out_rd = ordy;
    cycle();
  endtask

  task automatic quiet();
    bus.wr_en      = 1'b0;
    bus.sticky_set = 1'b0;
    bus.sticky_clr = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < LUT_N; k++) ref_lut[k] = DATA_W'(k);
    n_adv = 0; exp_vld = 1'b0; exp_data = '0; exp_sticky = 1'b0; exp_cnt = '0;
    bus.in_idx = '0; bus.in_vld = 1'b0; bus.out_rd = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.cmp_thr = '0; bus.sticky_set = 1'b0; bus.sticky_clr = 1'b0;

    // 1: reset, then a single index 3
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    rst_n = 1'b1;
    check("t1_in_rd_after_rst", {31'd0, bus.in_rd}, 32'd1);
    drive(1'b1, 2'd3, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    check("t1_out_vld", {31'd0, bus.out_vld}, 32'd1);
    check("t1_out_data", 32'(bus.out_data), 32'h03);
    check("t1_acc_cnt", 32'(bus.acc_cnt), 32'd1);

    // 2: write LUT[2]=A5, stream 0..3 back to back
    bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 8'hA5;
    drive(1'b0, 2'd0, 1'b1);
    quiet();
    for (int i = 0; i < 4; i++) drive(1'b1, IDX_W'(i), 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    check("t2_out_data_last", 32'(bus.out_data), 32'h03);
    check("t2_acc_cnt", 32'(bus.acc_cnt), 32'd5);
    drive(1'b0, 2'd0, 1'b1);

    // 3: stream 0,1,2 with out_rd low from the first output
    drive(1'b1, 2'd0, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    check("t3_first_out", 32'(bus.out_data), 32'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd2, 1'b0);
    check("t3_hold_data", 32'(bus.out_data), 32'h00);
    check("t3_hold_vld", {31'd0, bus.out_vld}, 32'd1);
    check("t3_in_rd_low", {31'd0, bus.in_rd}, 32'd0);
    drive(1'b1, 2'd2, 1'b1);
    check("t3_second_out", 32'(bus.out_data), 32'h01);
    drive(1'b0, 2'd0, 1'b1);
    check("t3_third_out", 32'(bus.out_data), 32'hA5);
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 1'b1);

    // 4: write LUT[1]=77 on the edge that reads idx 1
    drive(1'b1, 2'd1, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 8'h77;
    drive(1'b0, 2'd0, 1'b1);
    quiet();
    check("t4_old_value", 32'(bus.out_data), 32'h01);
    drive(1'b1, 2'd1, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    check("t4_new_value", 32'(bus.out_data), 32'h77);

    // 5: sticky flag and threshold compare
    bus.sticky_set = 1'b1;
    drive(1'b0, 2'd0, 1'b1);
    bus.sticky_set = 1'b0;
    check("t5_sticky_set", {31'd0, bus.sticky}, 32'd1);
    drive(1'b0, 2'd0, 1'b1);
    check("t5_sticky_hold", {31'd0, bus.sticky}, 32'd1);
    bus.sticky_set = 1'b1; bus.sticky_clr = 1'b1;
    drive(1'b0, 2'd0, 1'b1);
    check("t5_set_wins", {31'd0, bus.sticky}, 32'd1);
    bus.sticky_set = 1'b0;
    drive(1'b0, 2'd0, 1'b1);
    bus.sticky_clr = 1'b0;
    check("t5_cleared", {31'd0, bus.sticky}, 32'd0);
    bus.cmp_thr = 8'h02;
    drive(1'b1, 2'd3, 1'b1);
    drive(1'b1, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    check("t5_ge_03", {31'd0, bus.out_ge_thr}, 32'd1);
    drive(1'b0, 2'd0, 1'b1);
    check("t5_ge_00", {31'd0, bus.out_ge_thr}, 32'd0);
    bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 8'h01;
    drive(1'b1, 2'd1, 1'b1);
    quiet();
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    check("t5_ge_01", {31'd0, bus.out_ge_thr}, 32'd0);

    // 6: reset with two items in flight, LUT survives
    bus.sticky_set = 1'b1;
    drive(1'b1, 2'd3, 1'b1);
    bus.sticky_set = 1'b0;
    drive(1'b1, 2'd2, 1'b1);
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b1);
    rst_n = 1'b1;
    check("t6_vld", {31'd0, bus.out_vld}, 32'd0);
    check("t6_cnt", 32'(bus.acc_cnt), 32'd0);
    check("t6_sticky", {31'd0, bus.sticky}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 1'b1);
      check("t6_no_stale", {31'd0, bus.out_vld}, 32'd0);
    end
    drive(1'b1, 2'd2, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 1'b1);
    check("t6_lut_kept", 32'(bus.out_data), 32'hA5);

    // Random phase against the model
    for (int i = 0; i < 600; i++) begin
      bus.wr_en      = ($urandom_range(0, 9) == 0);
      bus.wr_addr    = IDX_W'($urandom);
      bus.wr_data    = DATA_W'($urandom);
      bus.cmp_thr    = DATA_W'($urandom);
      bus.sticky_set = ($urandom_range(0, 15) == 0);
      bus.sticky_clr = ($urandom_range(0, 7) == 0);
      rst_n          = ($urandom_range(0, 99) != 0);
      drive(($urandom_range(0, 3) != 0), IDX_W'($urandom), ($urandom_range(0, 9) < 7));
    end
    rst_n = 1'b1;
    quiet();
    for (int i = 0; i < DELAY + 2; i++) drive(1'b0, 2'd0, 1'b1);
    check("drain_empty", 32'(inflight.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
